mulf_seq: RTL and testbench



---
 rtl/float_pkg.sv | 27 ++
 rtl/umul24_seq.sv | 44 ++++
 rtl/mulf_seq.sv | 114 +++++++++++
 tb/tb_mulf_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared single-precision float definitions for the ALU float unit.
// Holds the multiplier state encoding, format constants and field helpers.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          MANT_W  = 24;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/umul24_seq.sv
// Unsigned 24x24 radix-2 shift-add multiplier, one partial product per step.
// 'last' is high during the final step so the caller can leave on the same edge.
module umul24_seq
    import float_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [MANT_W-1:0]       mcand_in,
    input  logic [MANT_W-1:0]       mplr_in,
    output logic [2*MANT_W-1:0]     prod,
    output logic                    last
);

    logic [2*MANT_W-1:0] mcand;
    logic [2*MANT_W-1:0] acc;
    logic [MANT_W-1:0]   mplr;
    logic [4:0]          cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= {{MANT_W{1'b0}}, mcand_in};
            acc   <= '0;
            mplr  <= mplr_in;
            cnt   <= '0;
        end else if (step) begin
            if (mplr[0])
                acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 5'd1;
        end
    end

    assign prod = acc;
    assign last = (cnt == 5'(MANT_W - 1));

endmodule

// File: rtl/mulf_seq.sv
// Multi-cycle single-precision multiplier: start/busy/done handshake around the
// shift-add mantissa engine, with truncating normalisation and simplified specials.
module mulf_seq
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        busy,
    output logic        done
);

    localparam logic signed [9:0] BIAS10 = 10'(BIAS);

    state_t state, next_state;

    logic [31:0]           areg, breg;
    logic                  load, step, last;
    logic [2*MANT_W-1:0]   prod;
    logic                  sign;
    logic [7:0]            ea, eb;
    logic signed [9:0]     e_sum, e_norm;
    logic [22:0]           frac;
    logic [31:0]           res;

    umul24_seq u_mant (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .mcand_in ({1'b1, f_frac(a)}),
        .mplr_in  ({1'b1, f_frac(b)}),
        .prod     (prod),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (last)
                    next_state = NORM;
            end
            NORM:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result path works only from captured operands, so a/b may move after start.
    always_comb begin
        sign   = f_sign(areg) ^ f_sign(breg);
        ea     = f_exp(areg);
        eb     = f_exp(breg);
        e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS10;
        e_norm = e_sum;
        frac   = prod[45:23];
        if (prod[47]) begin
            e_norm = e_sum + 10'sd1;
            frac   = prod[46:24];
        end
        if (ea == EXP_MAX || eb == EXP_MAX)
            res = {sign, EXP_MAX, 23'h0};
        else if (ea == 8'h00 || eb == 8'h00)
            res = {sign, 31'h0};
        else if (e_norm >= 10'sd255)
            res = {sign, EXP_MAX, 23'h0};
        else if (e_norm <= 10'sd0)
            res = {sign, 31'h0};
        else
            res = {sign, e_norm[7:0], frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            s    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                areg <= a;
                breg <= b;
                busy <= 1'b1;
            end
            if (state == NORM) begin
                s    <= res;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mulf_seq.sv
// Scoreboard bench for mulf_seq: stimulus pushes expected results and done cycles,
// an independent monitor pops and compares on every done pulse.
module tb_mulf_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] s;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] s;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int   cyc      = 0;
    int   compared = 0;
    int   failed   = 0;

    mulf_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called right after a falling edge; start is seen by the next rising edge.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev);
        exp_t e;
        a       = av;
        b       = bv;
        start   = 1'b1;
        e.s     = ev;
        e.cyc   = cyc + 26;
        expq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            compared++;
            failed++;
            $display("[TB] FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (expq.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_done: got done with s=0x%08h, expected none", s);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("result", s, e.s);
                checkOutput("latency", 32'(cyc), 32'(e.cyc));
                checkOutput("busy_at_done", {31'b0, busy}, 32'h0);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_s", s, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic values and the P[47] normalise path
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000);
        checkOutput("busy_after_start", {31'b0, busy}, 32'h1);
        waitDone();
        @(negedge clk);
        checkOutput("done_one_cycle", {31'b0, done}, 32'h0);
        applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        waitDone();
        @(negedge clk);

        // Sign, signed zero, overflow, underflow, infinity operand
        applyStimulus(32'h80000000, 32'h3F800000, 32'h80000000);
        waitDone();
        @(negedge clk);
        applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000);
        waitDone();
        @(negedge clk);
        applyStimulus(32'h00800000, 32'h00800000, 32'h00000000);
        waitDone();
        @(negedge clk);
        applyStimulus(32'h7F800000, 32'h3F800000, 32'h7F800000);
        waitDone();
        @(negedge clk);

        // Start while busy is ignored; operands also change after capture
        applyStimulus(32'hC0000000, 32'h3F000000, 32'hBF800000);
        repeat (4) @(negedge clk);
        a     = 32'h7F000000;
        b     = 32'h7F000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        @(negedge clk);

        // Back-to-back: new start in the done cycle
        applyStimulus(32'h40000000, 32'h3FC00000, 32'h40400000);
        waitDone();
        applyStimulus(32'h40400000, 32'h40400000, 32'h41100000);
        waitDone();
        @(negedge clk);

        // Asynchronous reset mid-operation
        applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_s", s, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        checkOutput("abort_done", {31'b0, done}, 32'h0);
        void'(expq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000);
        waitDone();
        repeat (3) @(negedge clk);

        checkOutput("queue_drained", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
